// File: rtl/turn_timer_if.sv
// Control and display bundle for the Hangman per-turn countdown timer.
// The master drives the controls, and the slave (the timer) drives the digits and status.
interface turn_timer_if;
   logic       tick;
   logic       load;
   logic [6:0] load_value;
   logic       start;
   logic       pause;
   logic       guess_made;
   logic [3:0] tens;
   logic [3:0] ones;
   logic       running;
   logic       warn;
   logic       expired;
   logic       timed_out;

   modport master (
      output tick, load, load_value, start, pause, guess_made,
      input  tens, ones, running, warn, expired, timed_out
   );

   modport slave (
      input  tick, load, load_value, start, pause, guess_made,
      output tens, ones, running, warn, expired, timed_out
   );
endinterface

// File: rtl/turn_timer.sv
// Two-digit BCD per-turn countdown with IDLE/RUN/PAUSED/EXPIRED control.
// It advances one step per tick, and a guess reloads the timer without stopping it.
module turn_timer #(
   parameter int START_SECS = 30,
   parameter int WARN_SECS  = 5
) (
   input  logic         clock,
   input  logic         reset,
   turn_timer_if.slave  bus
);

   generate
      if (START_SECS < 1 || START_SECS > 99) begin : g_bad_start
         $error("turn_timer: START_SECS must be in 1..99");
      end
      if (WARN_SECS >= START_SECS) begin : g_bad_warn
         $error("turn_timer: WARN_SECS must be below START_SECS");
      end
   endgenerate

   localparam logic [3:0] START_TENS = 4'(START_SECS / 10);
   localparam logic [3:0] START_ONES = 4'(START_SECS % 10);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic [3:0] r_tens;
   logic [3:0] r_ones;
   logic [3:0] w_tens_next;
   logic [3:0] w_ones_next;
   logic       r_expired;

   logic [6:0] w_clamped;
   logic [3:0] w_load_tens;
   logic [3:0] w_load_ones;
   logic       w_is_zero;
   logic       w_is_one;
   logic [6:0] w_count_bin;

   assign w_clamped   = (bus.load_value > 7'd99) ? 7'd99 : bus.load_value;
   assign w_load_tens = 4'(w_clamped / 7'd10);
   assign w_load_ones = 4'(w_clamped % 7'd10);
   assign w_is_zero   = (r_tens == 4'd0) && (r_ones == 4'd0);
   assign w_is_one    = (r_tens == 4'd0) && (r_ones == 4'd1);
   assign w_count_bin = ({3'b000, r_tens} * 7'd10) + {3'b000, r_ones};

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_tens    <= START_TENS;
         r_ones    <= START_ONES;
         r_expired <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_tens    <= w_tens_next;
         r_ones    <= w_ones_next;
         r_expired <= (w_state_next == ST_EXPIRED) && (r_state != ST_EXPIRED);
      end
   end

   // Load wins everywhere; within RUN/PAUSED, guess beats pause, which beats start, which beats tick.
   always_comb begin
      w_state_next = r_state;
      w_tens_next  = r_tens;
      w_ones_next  = r_ones;
      if (bus.load) begin
         w_state_next = ST_IDLE;
         w_tens_next  = w_load_tens;
         w_ones_next  = w_load_ones;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (bus.start && !w_is_zero) w_state_next = ST_RUN;
            end
            ST_RUN: begin
               if (bus.guess_made) begin
                  w_tens_next = START_TENS;
                  w_ones_next = START_ONES;
               end else if (bus.pause) begin
                  w_state_next = ST_PAUSED;
               end else if (bus.tick && !w_is_zero) begin
                  if (w_is_one) w_state_next = ST_EXPIRED;
                  if (r_ones != 4'd0) begin
                     w_ones_next = r_ones - 4'd1;
                  end else begin
                     w_ones_next = 4'd9;
                     w_tens_next = r_tens - 4'd1;
                  end
               end
            end
            ST_PAUSED: begin
               if (bus.guess_made) begin
                  w_state_next = ST_RUN;
                  w_tens_next  = START_TENS;
                  w_ones_next  = START_ONES;
               end else if (!bus.pause && bus.start) begin
                  w_state_next = ST_RUN;
               end
            end
            ST_EXPIRED: begin
               w_state_next = ST_EXPIRED;
            end
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   assign bus.tens      = r_tens;
   assign bus.ones      = r_ones;
   assign bus.running   = (r_state == ST_RUN);
   assign bus.warn      = (r_state == ST_RUN) && !w_is_zero && (w_count_bin <= 7'(WARN_SECS));
   assign bus.expired   = r_expired;
   assign bus.timed_out = (r_state == ST_EXPIRED);

endmodule
